alu_mc: RTL and testbench

Parametrised, registered successor to the single-cycle RV64 ALU for the multi-cycle core datapath. It keeps the existing five ALUop encodings and adds shifts, set-less-than, and iterative multiply, divide and remainder. Operands are accepted over a valid/ready handshake, and each result is held with a zero flag until the consumer takes it. Decode/issue logic drives it; the writeback mux consumes it.

---
 rtl/alu_mc.sv | 141 ++++++++++++++
 tb/tb_alu_mc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Registered RV64-style ALU: single-cycle ops done 1 cycle after accept, mul/divu/remu after WIDTH+1.
// Accepts only in IDLE; a DONE result is held with out_valid high until out_ready, for any stall length.
module alu_mc #(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             multi;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx, fin;

  assign shamt = in_1[SHW-1:0];
  assign multi = (ALUop == OP_MUL) || (ALUop == OP_DIVU) || (ALUop == OP_REMU);

  always_comb begin
    alu_res = '0;
    case (ALUop)
      OP_AND:  alu_res = in_0 & in_1;
      OP_OR:   alu_res = in_0 | in_1;
      OP_ADD:  alu_res = in_0 + in_1;
      OP_XOR:  alu_res = in_0 ^ in_1;
      OP_SUB:  alu_res = in_0 - in_1;
      OP_SLL:  alu_res = in_0 << shamt;
      OP_SRL:  alu_res = in_0 >> shamt;
      OP_SRA:  alu_res = $signed(in_0) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_0) < $signed(in_1))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_0 < in_1)};
      default: alu_res = '0;
    endcase
  end

  // mul: acc = partial product, opa = shifted multiplicand, opb = remaining multiplier.
  // div: acc = partial remainder, opa = dividend shifting out / quotient shifting in, opb = divisor.
  always_comb begin
    acc_nx = acc;
    opa_nx = opa;
    opb_nx = opb;
    rem_sh = {acc, opa[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb};
    if (op == OP_MUL) begin
      acc_nx = opb[0] ? acc + opa : acc;
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end else if (!diff[WIDTH]) begin
      acc_nx = diff[WIDTH-1:0];
      opa_nx = {opa[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = rem_sh[WIDTH-1:0];
      opa_nx = {opa[WIDTH-2:0], 1'b0};
    end
    fin = (op == OP_DIVU) ? opa_nx : acc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op       <= ALUop;
          in_ready <= 1'b0;
          if (multi) begin
            acc   <= '0;
            opa   <= in_0;
            opb   <= in_1;
            cnt   <= SHW'(WIDTH-1);
            state <= BUSY;
          end else begin
            out       <= alu_res;
            zero      <= (alu_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        BUSY: begin
          acc <= acc_nx;
          opa <= opa_nx;
          opb <= opb_nx;
          if (cnt == '0) begin
            out       <= fin;
            zero      <= (fin == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and random checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_0, in_1;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        zero;

  int checks = 0;
  int failures = 0;
  int lat;
  logic [63:0] held;

  alu_mc #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_0(in_0), .in_1(in_1), .ALUop(ALUop), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [5:0] sh;
    sh = b[5:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return $signed(a) >>> sh;
      4'b1000: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1001: return (a < b) ? 64'd1 : 64'd0;
      4'b1010: return a * b;
      4'b1100: return (b == 0) ? {64{1'b1}} : a / b;
      4'b1101: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'b1010 || op == 4'b1100 || op == 4'b1101) ? 65 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input int stall);
    logic [63:0] e;
    e = ref_alu(op, a, b);
    chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; ALUop = op; in_0 = a; in_1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; ALUop = 4'($urandom); in_0 = {$urandom, $urandom}; in_1 = {$urandom, $urandom};
    wait_valid();
    chk({tag, ":lat"}, 64'(lat), 64'(ref_lat(op)));
    chk({tag, ":out"}, out, e);
    chk({tag, ":zero"}, 64'(zero), 64'(e == 0));
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ":idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ":hold"}, out, e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_0 = '0; in_1 = '0; ALUop = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst:in_ready", 64'(in_ready), 64'd1);
    chk("rst:out_valid", 64'(out_valid), 64'd0);
    chk("rst:out", out, 64'd0);
    chk("rst:zero", 64'(zero), 64'd1);

    run("xor", 4'b0011, 64'hF0F0, 64'h0FF0, 0);

    // mul aborted by reset in its 10th BUSY cycle
    in_valid = 1'b1; ALUop = 4'b1010; in_0 = 64'd5; in_1 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst:in_ready", 64'(in_ready), 64'd1);
    chk("arst:out_valid", 64'(out_valid), 64'd0);
    chk("arst:out", out, 64'd0);
    chk("arst:zero", 64'(zero), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("arst:no_late_valid", 64'(out_valid), 64'd0);
    chk("arst:no_partial", out, 64'd0);
    run("add37", 4'b0010, 64'd3, 64'd4, 0);

    run("sub55", 4'b0110, 64'd5, 64'd5, 0);
    run("add_wrap", 4'b0010, {64{1'b1}}, 64'd1, 0);
    run("and", 4'b0000, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 0);
    run("or", 4'b0001, 64'hA000_0000_0000_0005, 64'h0000_0000_0000_0050, 0);
    run("sra", 4'b0111, 64'h8000_0000_0000_0000, 64'h43, 0);
    run("sll", 4'b0100, 64'h1, 64'h7F, 0);
    run("srl", 4'b0101, 64'h8000_0000_0000_0000, 64'h3F, 1);
    run("slt", 4'b1000, {64{1'b1}}, 64'd1, 0);
    run("sltu", 4'b1001, {64{1'b1}}, 64'd1, 0);
    run("mul", 4'b1010, 64'h1_0000_0001, 64'd3, 0);
    run("divu", 4'b1100, 64'd100, 64'd7, 0);
    run("remu", 4'b1101, 64'd100, 64'd7, 0);
    run("divu0", 4'b1100, 64'd42, 64'd0, 0);
    run("remu0", 4'b1101, 64'd42, 64'd0, 0);
    run("unused", 4'b1110, 64'd9, 64'd9, 2);

    // backpressure: stall DONE 20 cycles while a new request is offered
    in_valid = 1'b1; ALUop = 4'b1100; in_0 = 64'd1000; in_1 = 64'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    chk("bp:lat", 64'(lat), 64'd65);
    held = out;
    chk("bp:out", held, 64'd111);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; ALUop = 4'b0010; in_0 = 64'd1; in_1 = 64'd1;
      @(posedge clk); #1;
      chk("bp:valid", 64'(out_valid), 64'd1);
      chk("bp:stable", out, 64'd111);
      chk("bp:in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp:release_ready", 64'(in_ready), 64'd1);
    chk("bp:release_valid", 64'(out_valid), 64'd0);
    chk("bp:no_capture", out, 64'd111);
    chk("bp:zero", 64'(zero), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [63:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      run("rand", rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
